// File: rtl/cu_array.sv
// cu_array: row of LANES signed multiply-accumulate lanes with per-lane
// micro-ops (NOP/MAC/BIAS/OUT) and fused output requantisation (arithmetic
// right shift, optional ReLU, saturation to DATA_W). There is a valid/ready
// handshake on the input beat and on the result beat.
//
// Ports:
//   clk, rst      - single clock, synchronous active-high reset
//   flush         - synchronous clear of accumulators, flags, pending result
//   in_valid/in_ready - input beat handshake
//   op            - 2 bits per lane: 00 NOP, 01 MAC, 10 BIAS, 11 OUT
//   x, w          - per-lane signed operands (x is the bias value for BIAS)
//   relu_en       - clamp negative results to zero on OUT lanes
//   out_valid/out_ready - result beat handshake
//   out_data      - per-lane signed result
//   out_mask      - lanes carrying a result in this beat
//   out_sat       - lane result was clipped to DATA_W
//   acc_ovf       - sticky per-lane accumulator saturation flag
module cu_array #(
  parameter int LANES  = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*LANES-1:0]        op,
  input  logic [LANES*DATA_W-1:0]   x,
  input  logic [LANES*DATA_W-1:0]   w,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_mask,
  output logic [LANES-1:0]          out_sat,
  output logic [LANES-1:0]          acc_ovf
);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_MAC  = 2'b01,
    OP_BIAS = 2'b10,
    OP_OUT  = 2'b11
  } op_e;

  logic [LANES*ACC_W-1:0]  acc;
  logic [LANES*ACC_W-1:0]  acc_next;
  logic [LANES*DATA_W-1:0] lane_out;
  logic [LANES-1:0]        is_out;
  logic [LANES-1:0]        res_sat;
  logic [LANES-1:0]        ovf_hit;
  logic                    accept;
  logic                    any_out;

  assign in_ready = !rst && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign any_out  = |is_out;

  for (genvar g = 0; g < LANES; g++) begin : lane
    op_e                      lop;
    logic signed [DATA_W-1:0] xi;
    logic signed [DATA_W-1:0] wi;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_cur;
    logic signed [ACC_W:0]    sum;
    logic                     clip_acc;
    logic signed [ACC_W-1:0]  s;
    logic signed [ACC_W-1:0]  r;
    logic signed [ACC_W-1:0]  rl;
    logic [ACC_W-DATA_W:0]    hi;
    logic                     fits;
    logic [DATA_W-1:0]        res;
    logic [ACC_W-1:0]         bias;

    assign lop     = op_e'(op[2*g +: 2]);
    assign xi      = x[g*DATA_W +: DATA_W];
    assign wi      = w[g*DATA_W +: DATA_W];
    assign acc_cur = acc[g*ACC_W +: ACC_W];

    // Operands widened first so the product is the full 2*DATA_W value.
    assign prod = $signed({{DATA_W{xi[DATA_W-1]}}, xi}) *
                  $signed({{DATA_W{wi[DATA_W-1]}}, wi});

    assign sum = {acc_cur[ACC_W-1], acc_cur} +
                 {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // Overflow of the ACC_W+1 sum shows up as the top two bits disagreeing.
    assign clip_acc = sum[ACC_W] ^ sum[ACC_W-1];
    assign s = clip_acc ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}}
                        : sum[ACC_W-1:0];

    assign r  = s >>> SHIFT;
    assign rl = (relu_en && r[ACC_W-1]) ? '0 : r;

    // Result fits DATA_W when all bits from the DATA_W sign bit up agree.
    assign hi   = rl[ACC_W-1:DATA_W-1];
    assign fits = (hi == '0) || (hi == '1);
    assign res  = fits ? rl[DATA_W-1:0]
                       : {rl[ACC_W-1], {(DATA_W-1){~rl[ACC_W-1]}}};

    // Bias is pre-scaled so it lands in output scale after the final shift.
    assign bias = {{(ACC_W-DATA_W){xi[DATA_W-1]}}, xi} << SHIFT;

    assign is_out[g]  = (lop == OP_OUT);
    assign res_sat[g] = is_out[g] && !fits;
    assign ovf_hit[g] = ((lop == OP_MAC) || (lop == OP_OUT)) && clip_acc;
    assign lane_out[g*DATA_W +: DATA_W] = is_out[g] ? res : '0;

    assign acc_next[g*ACC_W +: ACC_W] =
      (lop == OP_MAC)  ? s    :
      (lop == OP_BIAS) ? bias :
      (lop == OP_OUT)  ? '0   : acc_cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_ovf   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_sat   <= '0;
    end else if (flush) begin
      acc       <= '0;
      acc_ovf   <= '0;
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_sat   <= '0;
    end else begin
      if (accept) begin
        acc     <= acc_next;
        acc_ovf <= acc_ovf | ovf_hit;
      end
      // A new OUT beat can only be accepted when the old result is free or
      // consumed this cycle, so loading here covers the no-bubble reload.
      if (accept && any_out) begin
        out_valid <= 1'b1;
        out_data  <= lane_out;
        out_mask  <= is_out;
        out_sat   <= res_sat;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cu_array.md
# cu_array

Parametrised compute unit: a row of `LANES` signed multiply-accumulate lanes, with per-lane micro-ops, fused output scaling (arithmetic shift, optional ReLU, saturation), and a valid/ready handshake on both the input beat and the result beat. It sits between the kernel/feature operand fetch and the output write-back buffer of the conv datapath. It replaces the fixed `PE_NUM` array with configurable lane count, operand and accumulator width, and output requantisation.

## Interface
- `LANES`, 8, number of MAC lanes
- `DATA_W`, 8, signed operand and result width
- `ACC_W`, 24, signed accumulator width; constraint ACC_W ≥ 2·DATA_W+1
- `SHIFT`, 0, output right-shift (arithmetic); constraint SHIFT ≤ ACC_W−DATA_W−1

Ports:
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — synchronous, active-high reset
- `flush` in 1 — synchronous clear of accumulators, flags and pending result
- `in_valid` in 1 — input beat valid
- `in_ready` out 1 — input beat accepted when `in_valid && in_ready`
- `op` in 2·LANES — per-lane micro-op: 00 NOP, 01 MAC, 10 BIAS, 11 OUT
- `x` in LANES·DATA_W — per-lane signed feature operand (bias value for BIAS)
- `w` in LANES·DATA_W — per-lane signed kernel operand
- `relu_en` in 1 — sampled on each accepted beat; clamps negative results to 0
- `out_valid` out 1 — result beat valid
- `out_ready` in 1 — result beat consumed when `out_valid && out_ready`
- `out_data` out LANES·DATA_W — per-lane signed result
- `out_mask` out LANES — lanes carrying a result in this beat
- `out_sat` out LANES — lane result was clipped to DATA_W
- `acc_ovf` out LANES — sticky: lane accumulator saturated since last reset/flush

## Operation
- `in_ready = !rst && !flush && (!out_valid || out_ready)`. This is combinational and independent of `op`.
- On an accepted beat, each lane acts on its own `op`:
  - NOP: acc unchanged.
  - MAC: acc ← sat_ACC(acc + x·w).
  - BIAS: acc ← sign_ext(x) <<< SHIFT, so the bias is expressed in output scale.
  - OUT: s = sat_ACC(acc + x·w); r = s >>> SHIFT; if `relu_en` and r<0 then r=0; result = sat_DATA(r). Then acc ← 0.
- Product is a full 2·DATA_W signed value, sign-extended to ACC_W. The sum is computed in ACC_W+1 bits.
- sat_ACC clips to [−2^(ACC_W−1), 2^(ACC_W−1)−1] and sets that lane's `acc_ovf` when it clips.
- sat_DATA clips to [−2^(DATA_W−1), 2^(DATA_W−1)−1] and sets `out_sat[i]` when it clips.
- If any lane has OUT on an accepted beat, the result register loads:
  - `out_mask[i]` = (op_i==OUT).
  - OUT lanes carry their result and sat bit.
  - Non-OUT lanes carry `out_data` 0 and `out_sat` 0.
  - `out_valid` is set.
- A beat with no OUT lane does not load the result register. `out_valid` clears on consume unless a new OUT beat is accepted in the same cycle, in which case the result register reloads and `out_valid` stays 1.
- `flush`, when high, for the following state:
  - accs, `acc_ovf`, `out_valid`, `out_mask` and `out_sat` become 0.
  - A pending result is dropped.
  - Any beat offered in that cycle is not accepted.
- `rst` has the same effect as `flush` and also zeroes `out_data`. `rst` has priority over everything.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_mask`=0, `out_sat`=0, `acc_ovf`=0, all accs 0. `in_ready`=0 while `rst`=1 and 1 on the first cycle after reset.
- Accumulate latency: a MAC/BIAS beat accepted at edge N is visible in acc after edge N. A MAC at edge N followed by an OUT at edge N+1 is therefore correctly fused.
- Result latency: an OUT beat accepted at edge N gives `out_valid`=1 from edge N through the consuming edge.
- Throughput: 1 beat/cycle while `out_ready`=1.
- `out_data`, `out_mask` and `out_sat` are held stable while `out_valid && !out_ready`. `in_ready`=0 for that duration, and accs are frozen.
- Simultaneous OUT on all lanes and a consume in the same cycle: the old beat is consumed and the new one loaded, with no bubble.
- Reset or flush in the middle of a backpressured result: the result is lost, and `out_valid`=0 on the next cycle.

## Test plan
Unless stated otherwise, all scenarios use `LANES`=4, `DATA_W`=8, `ACC_W`=24, `SHIFT`=0.

- **Reset.** Hold `rst` 3 cycles with `in_valid`=1 → no beat accepted; all outputs 0; `in_ready`=1 the cycle after release.
- **MAC then fused OUT.** Lane0 MAC x=3,w=4, then OUT x=−2,w=5 → `out_data[0]`=2, `out_mask`=0001, `out_sat`=0; a following OUT x=0 on lane0 returns 0 (acc cleared).
- **Bias, saturation, ReLU.**
  - BIAS x=100, then OUT x=10,w=10 → 127, `out_sat[0]`=1.
  - BIAS x=0, then OUT x=−10,w=10 with `relu_en`=1 → 0, `out_sat`=0; same with `relu_en`=0 → −100.
  - With `SHIFT`=2: BIAS x=5, then OUT x=0 → 5.
- **Backpressure.** OUT beat accepted, `out_ready`=0 for 4 cycles → `out_valid`=1 and data stable, `in_ready`=0, a second beat is held off; raise `out_ready` → second beat accepted in that cycle, back-to-back results.
- **Accumulator overflow.** 600 MAC beats of 127·127 on lane1 → acc=8388607, `acc_ovf[1]`=1 sticky; OUT x=0 → 127, `out_sat[1]`=1.
- **Flush mid-operation.** Accs non-zero, pending result, `out_ready`=0, assert `flush` with `in_valid`=1 → that beat not accepted; next cycle `out_valid`=0, `acc_ovf`=0, an OUT x=0 returns 0 on all lanes.
